// File: rtl/ddr3_burst_pkg.sv
// Shared types and helpers for the DDR3 burst read checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ddr3_burst_pkg;

  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;

  // One issued Avalon read burst.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burstcnt;
  } burst_req_t;

  // Expected data for the 64-bit word at addr: zero-extended address in the
  // upper half, its bitwise complement in the lower half.
  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] addr);
    logic [DATA_W/2-1:0] w;
    w = {3'b000, addr};
    return {w, ~w};
  endfunction

endpackage

// File: rtl/ddr3_req_fifo.sv
// Request queue of outstanding read bursts, combinational head read.
// Latency: push visible at head one cycle later; full/empty/count registered.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
//
// Ports: clk, reset_n (async, active-low); push/push_req write an entry;
// pop retires the head; full/empty/count report occupancy; head is the
// oldest entry (stale when empty).
module ddr3_req_fifo
  import ddr3_burst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  burst_req_t               push_req,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output burst_req_t               head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  burst_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    cnt_n = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_n = cnt_q + 1'b1;
      2'b01:   cnt_n = cnt_q - 1'b1;
      default: cnt_n = cnt_q;
    endcase
  end

  // full/empty are flopped from the next occupancy so they can drive
  // outputs directly without a decode after the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_n;
      full  <= (cnt_n == FULL_CNT);
      empty <= (cnt_n == '0);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/ddr3_burst_checker.sv
// Checks returning DDR3 read beats against issued bursts; stats and sticky errors.
// Latency: beat on edge n updates beat_idx/counters/flags at n+1; burst_done pulses in n+1.
// Backpressure: req_ready drops the cycle after the queue fills; beats are never stalled.
//
// Ports: clk, reset_n (async, active-low); req_valid/req_addr/req_burstcnt
// record an issued burst, req_ready = queue not full; dout/dout_ready carry
// read beats; mode selects pattern check; clear zeroes stats and flags;
// active, beat_idx, burst_done, err_* flags, burst_total, err_total and
// first_err_addr report status.
module ddr3_burst_checker
  import ddr3_burst_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [28:0] req_addr,
  input  logic [7:0]  req_burstcnt,
  output logic        req_ready,
  input  logic [63:0] dout,
  input  logic        dout_ready,
  input  logic        mode,
  input  logic        clear,
  output logic        active,
  output logic [7:0]  beat_idx,
  output logic        burst_done,
  output logic        err_mismatch,
  output logic        err_overrun,
  output logic        err_timeout,
  output logic        err_proto,
  output logic [15:0] burst_total,
  output logic [15:0] err_total,
  output logic [28:0] first_err_addr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [9:0]       IDLE_LAST = 10'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_n;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  burst_req_t        head, push_req;

  logic              push_ok, beat, last_beat, mismatch, timeout_hit, pop;
  logic              mism_base;
  logic [ADDR_W-1:0] beat_addr;
  logic [9:0]        idle_q, idle_n;

  logic [7:0]        beat_idx_n;
  logic              burst_done_n;
  logic              err_mismatch_n, err_overrun_n, err_timeout_n, err_proto_n;
  logic [15:0]       burst_total_n, err_total_n;
  logic [28:0]       first_err_addr_n;

  assign push_req  = '{addr: req_addr, burstcnt: req_burstcnt};
  assign push_ok   = req_valid & ~full & (req_burstcnt != '0);
  assign req_ready = ~full;
  assign active    = (state_q == S_RUN);

  ddr3_req_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_ok),
    .push_req (push_req),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  always_comb begin
    beat        = (state_q == S_RUN) & ~empty & dout_ready;
    beat_addr   = head.addr + ADDR_W'(beat_idx);
    last_beat   = beat & (beat_idx == head.burstcnt - 1'b1);
    mismatch    = beat & mode & (dout != exp_word(beat_addr));
    // Abandon the head once TIMEOUT consecutive beat-less cycles have elapsed.
    timeout_hit = (state_q == S_RUN) & ~dout_ready & (idle_q == IDLE_LAST);
    pop         = last_beat | timeout_hit;

    state_n = state_q;
    case (state_q)
      S_IDLE: if (push_ok) state_n = S_RUN;
      S_RUN:  if (pop && !push_ok && count == ONE_CNT) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_q != S_RUN || beat || pop) idle_n = '0;
    else                                 idle_n = idle_q + 1'b1;

    beat_idx_n = beat_idx;
    if (pop)       beat_idx_n = '0;
    else if (beat) beat_idx_n = beat_idx + 1'b1;

    burst_done_n = last_beat;

    // Clear acts first; same-cycle events then land on the cleared values.
    burst_total_n = clear ? '0 : burst_total;
    if (last_beat && burst_total_n != 16'hFFFF) burst_total_n = burst_total_n + 1'b1;

    err_total_n = clear ? '0 : err_total;
    if (mismatch && err_total_n != 16'hFFFF) err_total_n = err_total_n + 1'b1;

    // A clear re-arms first_err_addr capture.
    mism_base        = err_mismatch & ~clear;
    err_mismatch_n   = mism_base | mismatch;
    first_err_addr_n = clear ? '0 : first_err_addr;
    if (mismatch && !mism_base) first_err_addr_n = beat_addr;

    err_overrun_n = (err_overrun & ~clear) | ((state_q == S_IDLE) & dout_ready);
    err_timeout_n = (err_timeout & ~clear) | timeout_hit;
    err_proto_n   = (err_proto & ~clear) | (req_valid & (full | (req_burstcnt == '0)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_q         <= '0;
      beat_idx       <= '0;
      burst_done     <= 1'b0;
      err_mismatch   <= 1'b0;
      err_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
      err_proto      <= 1'b0;
      burst_total    <= '0;
      err_total      <= '0;
      first_err_addr <= '0;
    end else begin
      idle_q         <= idle_n;
      beat_idx       <= beat_idx_n;
      burst_done     <= burst_done_n;
      err_mismatch   <= err_mismatch_n;
      err_overrun    <= err_overrun_n;
      err_timeout    <= err_timeout_n;
      err_proto      <= err_proto_n;
      burst_total    <= burst_total_n;
      err_total      <= err_total_n;
      first_err_addr <= first_err_addr_n;
    end
  end

endmodule

// File: tb/tb_ddr3_burst_checker.sv
`timescale 1ns/1ps
module tb_ddr3_burst_checker;
  import ddr3_burst_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [28:0] req_addr;
  logic [7:0]  req_burstcnt;
  logic        req_ready;
  logic [63:0] dout;
  logic        dout_ready;
  logic        mode;
  logic        clear;
  logic        active;
  logic [7:0]  beat_idx;
  logic        burst_done;
  logic        err_mismatch, err_overrun, err_timeout, err_proto;
  logic [15:0] burst_total, err_total;
  logic [28:0] first_err_addr;

  always #5 clk = ~clk;

  ddr3_burst_checker #(.DEPTH(DEPTH), .TIMEOUT(1023)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_burstcnt   (req_burstcnt),
    .req_ready      (req_ready),
    .dout           (dout),
    .dout_ready     (dout_ready),
    .mode           (mode),
    .clear          (clear),
    .active         (active),
    .beat_idx       (beat_idx),
    .burst_done     (burst_done),
    .err_mismatch   (err_mismatch),
    .err_overrun    (err_overrun),
    .err_timeout    (err_timeout),
    .err_proto      (err_proto),
    .burst_total    (burst_total),
    .err_total      (err_total),
    .first_err_addr (first_err_addr)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       done;
    logic [7:0] idx;
  } sb_t;

  burst_req_t mq[$];   // model of the request queue
  int         m_idx;   // model beat index within head burst
  sb_t        sb[$];   // expected per-beat outputs

  typedef struct {
    logic        valid;
    logic [28:0] addr;
    logic [7:0]  cnt;
    logic        clr;
    logic        exp_ready;
    logic        exp_proto;
    logic        exp_active;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [28:0] a, input int k);
    logic [28:0] w;
    logic [31:0] x;
    w = a + 29'(k);
    x = {3'b000, w};
    return {x, ~x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [28:0] a, input logic [7:0] c);
    burst_req_t r;
    r.addr = a;
    r.burstcnt = c;
    if (c != 8'd0 && mq.size() < DEPTH) mq.push_back(r);
  endtask

  task automatic push_burst(input logic [28:0] a, input logic [7:0] c);
    req_valid = 1'b1;
    req_addr = a;
    req_burstcnt = c;
    model_push(a, c);
    tick();
    req_valid = 1'b0;
  endtask

  // Drive one beat; the expected burst_done/beat_idx go to the scoreboard
  // and are popped and compared once the edge has happened.
  task automatic drive_beat(input logic [63:0] d, input logic clr);
    sb_t        e;
    burst_req_t t;
    dout = d;
    dout_ready = 1'b1;
    clear = clr;
    e.done = 1'b0;
    e.idx = 8'd0;
    if (mq.size() != 0) begin
      if (m_idx == int'(mq[0].burstcnt) - 1) begin
        e.done = 1'b1;
        t = mq.pop_front();
        m_idx = 0;
      end else begin
        m_idx++;
        e.idx = 8'(m_idx);
      end
    end
    sb.push_back(e);
    tick();
    dout_ready = 1'b0;
    clear = 1'b0;
    req_valid = 1'b0;
    e = sb.pop_front();
    chk("burst_done", {63'd0, burst_done}, {63'd0, e.done});
    chk("beat_idx", {56'd0, beat_idx}, {56'd0, e.idx});
  endtask

  task automatic good_beat();
    drive_beat(pat(mq[0].addr, m_idx), 1'b0);
  endtask

  initial begin
    vec_t vt[7];
    vt[0] = '{1'b1, 29'h100, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};  // zero-length burst
    vt[1] = '{1'b0, 29'h0,   8'd0, 1'b1, 1'b1, 1'b0, 1'b0};  // clear
    vt[2] = '{1'b1, 29'h100, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 29'h200, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 29'h300, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 29'h400, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1};  // fills queue
    vt[6] = '{1'b1, 29'h500, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1};  // dropped

    m_idx = 0;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_burstcnt = '0;
    dout = '0;
    dout_ready = 1'b0;
    mode = 1'b1;
    clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst active", {63'd0, active}, 64'd0);
    chk("rst beat_idx", {56'd0, beat_idx}, 64'd0);
    chk("rst burst_done", {63'd0, burst_done}, 64'd0);
    chk("rst flags", {60'd0, err_mismatch, err_overrun, err_timeout, err_proto}, 64'd0);
    chk("rst totals", {32'd0, burst_total, err_total}, 64'd0);
    chk("rst first_err_addr", {35'd0, first_err_addr}, 64'd0);

    // 128-beat clean burst
    push_burst(29'h2400000, 8'd128);
    chk("t1 active", {63'd0, active}, 64'd1);
    for (int k = 0; k < 128; k++) good_beat();
    chk("t1 burst_total", {48'd0, burst_total}, 64'd1);
    chk("t1 flags", {60'd0, err_mismatch, err_overrun, err_timeout, err_proto}, 64'd0);
    chk("t1 err_total", {48'd0, err_total}, 64'd0);
    chk("t1 active", {63'd0, active}, 64'd0);
    tick();
    chk("t1 done single", {63'd0, burst_done}, 64'd0);

    // Same burst, beat 5 corrupted
    push_burst(29'h2400000, 8'd128);
    for (int k = 0; k < 128; k++) begin
      logic [63:0] d;
      d = pat(29'h2400000, k);
      if (k == 5) d = d ^ 64'h1;
      drive_beat(d, 1'b0);
    end
    chk("t2 err_mismatch", {63'd0, err_mismatch}, 64'd1);
    chk("t2 err_total", {48'd0, err_total}, 64'd1);
    chk("t2 first_err_addr", {35'd0, first_err_addr}, 64'h2400005);
    chk("t2 burst_total", {48'd0, burst_total}, 64'd2);
    chk("t2 active", {63'd0, active}, 64'd0);

    // Queue fill / protocol errors, table driven
    for (int i = 0; i < 7; i++) begin
      req_valid = vt[i].valid;
      req_addr = vt[i].addr;
      req_burstcnt = vt[i].cnt;
      clear = vt[i].clr;
      if (vt[i].valid) model_push(vt[i].addr, vt[i].cnt);
      tick();
      req_valid = 1'b0;
      clear = 1'b0;
      chk($sformatf("vec%0d req_ready", i), {63'd0, req_ready}, {63'd0, vt[i].exp_ready});
      chk($sformatf("vec%0d err_proto", i), {63'd0, err_proto}, {63'd0, vt[i].exp_proto});
      chk($sformatf("vec%0d active", i), {63'd0, active}, {63'd0, vt[i].exp_active});
    end
    for (int k = 0; k < 8; k++) good_beat();
    chk("t3 burst_total", {48'd0, burst_total}, 64'd4);
    chk("t3 active", {63'd0, active}, 64'd0);
    chk("t3 req_ready", {63'd0, req_ready}, 64'd1);
    chk("t3 err_mismatch", {63'd0, err_mismatch}, 64'd0);

    // Timeout boundary, then overrun
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push_burst(29'h1000, 8'd4);
    good_beat();
    good_beat();
    repeat (1022) tick();
    chk("t4 no timeout yet", {63'd0, err_timeout}, 64'd0);
    chk("t4 still active", {63'd0, active}, 64'd1);
    tick();
    chk("t4 err_timeout", {63'd0, err_timeout}, 64'd1);
    chk("t4 active", {63'd0, active}, 64'd0);
    chk("t4 burst_total", {48'd0, burst_total}, 64'd0);
    chk("t4 beat_idx", {56'd0, beat_idx}, 64'd0);
    chk("t4 burst_done", {63'd0, burst_done}, 64'd0);
    begin
      burst_req_t t;
      t = mq.pop_front();
    end
    m_idx = 0;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("t4 err_overrun", {63'd0, err_overrun}, 64'd1);

    // Clear coinciding with a mismatching beat
    push_burst(29'h40, 8'd2);
    drive_beat(pat(29'h40, 0) ^ 64'h1, 1'b0);
    chk("t5 err_total pre", {48'd0, err_total}, 64'd1);
    chk("t5 first_err pre", {35'd0, first_err_addr}, 64'h40);
    drive_beat(pat(29'h40, 1) ^ 64'h2, 1'b1);
    chk("t5 err_total", {48'd0, err_total}, 64'd1);
    chk("t5 err_mismatch", {63'd0, err_mismatch}, 64'd1);
    chk("t5 first_err_addr", {35'd0, first_err_addr}, 64'h41);
    chk("t5 burst_total", {48'd0, burst_total}, 64'd1);
    chk("t5 err_overrun", {63'd0, err_overrun}, 64'd0);

    // Count-only mode, plus push on the cycle the last entry pops
    mode = 1'b0;
    push_burst(29'h80, 8'd2);
    drive_beat(64'hDEAD, 1'b0);
    req_valid = 1'b1;
    req_addr = 29'h90;
    req_burstcnt = 8'd1;
    model_push(29'h90, 8'd1);
    drive_beat(64'hBEEF, 1'b0);
    chk("t6 active", {63'd0, active}, 64'd1);
    chk("t6 err_total", {48'd0, err_total}, 64'd1);
    chk("t6 burst_total", {48'd0, burst_total}, 64'd2);
    mode = 1'b1;
    good_beat();
    chk("t6 burst_total end", {48'd0, burst_total}, 64'd3);
    chk("t6 active end", {63'd0, active}, 64'd0);

    // Asynchronous reset mid-burst
    push_burst(29'h3000, 8'd8);
    good_beat();
    good_beat();
    good_beat();
    #3;
    reset_n = 1'b0;
    #1;
    chk("t7 req_ready", {63'd0, req_ready}, 64'd1);
    chk("t7 active", {63'd0, active}, 64'd0);
    chk("t7 beat_idx", {56'd0, beat_idx}, 64'd0);
    chk("t7 err_mismatch", {63'd0, err_mismatch}, 64'd0);
    chk("t7 totals", {32'd0, burst_total, err_total}, 64'd0);
    chk("t7 first_err_addr", {35'd0, first_err_addr}, 64'd0);
    mq.delete();
    m_idx = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    push_burst(29'h10, 8'd1);
    good_beat();
    chk("t7 recovered", {48'd0, burst_total}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_checker.md
# ddr3_burst_checker

Downstream consumer of the DDR3 burst read stream. Records every issued Avalon read burst (address, burst count) in a small request queue. Consumes the returning `DDRAM_DOUT`/`DDRAM_DOUT_READY` beats, counts them against the head request, and optionally compares each beat to an address-derived pattern. Reports per-burst completion, sticky error flags and saturating statistics to the OSD/LED logic of the burst test core.

## Interface
Parameters:
- `DEPTH`, 4: request-queue entries (power of two, ≥2).
- `TIMEOUT`, 1023: idle cycles tolerated between beats of an outstanding burst (10-bit counter).

Ports:
- `clk` in 1: DDR3-side clock (`clk_ddr3`).
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: a read burst was accepted by DDR3 this cycle (`rd & ~DDRAM_BUSY`).
- `req_addr` in 29: burst start address (64-bit word units).
- `req_burstcnt` in 8: burst length in beats.
- `req_ready` out 1: queue not full.
- `dout` in 64: read data beat.
- `dout_ready` in 1: `dout` valid this cycle.
- `mode` in 1: 0 = count only, 1 = pattern check.
- `clear` in 1: synchronous clear of statistics and sticky errors.
- `active` out 1: a burst is outstanding (queue non-empty).
- `beat_idx` out 8: index of the next expected beat in the head burst.
- `burst_done` out 1: one-cycle pulse, head burst completed normally.
- `err_mismatch`, `err_overrun`, `err_timeout`, `err_proto` out 1 each: sticky error flags.
- `burst_total` out 16: completed bursts, saturating.
- `err_total` out 16: mismatching beats, saturating.
- `first_err_addr` out 29: address of the first mismatching beat since clear.

## Operation
- Expected word for beat k of a burst at A: w = A+k (29-bit, wraps mod 2^29); exp = {3'b0, w, ~{3'b0, w}}.
- States:
  - IDLE: queue empty.
  - RUN: head burst receiving beats.
- IDLE→RUN on push. RUN→IDLE when the head pops and no other entry remains.
- Push: on `req_valid & req_ready & req_burstcnt!=0`.
  - `req_burstcnt==0`: entry not pushed; sets `err_proto`.
  - `req_valid` while full: entry dropped; sets `err_proto`.
- Beat accepted in RUN on `dout_ready`:
  - In `mode=1`, compare `dout` to exp(head.addr + `beat_idx`).
  - On mismatch: set `err_mismatch`; increment `err_total`, saturating at 16'hFFFF. On the first mismatch since clear, latch `first_err_addr`.
  - Advance `beat_idx`. On beat `burstcnt-1`: pop the head, reset `beat_idx` to 0, pulse `burst_done`, increment `burst_total` (saturating).
- `dout_ready` in IDLE: beat ignored; sets `err_overrun`.
- Timeout: the idle counter counts RUN cycles without `dout_ready`. It resets on each beat and on each pop. When it reaches `TIMEOUT`: set `err_timeout`, pop the head (abandon the burst), reset `beat_idx`. No `burst_done`.
- Simultaneous push and pop: both take effect; occupancy is unchanged. A push in the same cycle a full queue pops is still refused, because `req_ready` is registered from occupancy.
- `clear`:
  - Zeroes `burst_total`, `err_total`, `first_err_addr` and all sticky flags.
  - Does not flush the queue, `beat_idx` or the timeout counter.
  - Same-cycle events are applied after the clear and are therefore recorded.
- `mode` is sampled per beat; changing it mid-burst affects only later beats.

## Timing
- All outputs are registered. Reset values: `req_ready=1`; all other outputs 0.
- Latency:
  - Beat on edge n → `beat_idx`, counters and flags update visibly at n+1.
  - `burst_done` is high during cycle n+1 only.
- Back-to-back beats every cycle are supported, including the last beat of one burst followed by beat 0 of the next queued burst on the following cycle.
- `req_ready` falls the cycle after the queue becomes full.
- `reset_n` low mid-burst: queue, state and all outputs return to reset values immediately (async). Release is synchronous to `clk`.

## Structure
- Package `ddr3_burst_pkg`:
  - `ADDR_W=29`, `DATA_W=64`, `BURST_W=8`.
  - Typedef `burst_req_t` {addr, burstcnt}.
  - Function `exp_word(addr)` implementing the pattern above.
- Sub-module `ddr3_req_fifo`:
  - Parameterised `DEPTH` FIFO of `burst_req_t`.
  - Ports: push/pop/full/empty/head.
  - Combinational head read.
- Top holds the FSM, beat counter, timeout counter, comparator and statistics.

## Test plan
- Push A=0x2400000, cnt=128, mode=1; 128 correct beats, one per cycle → `burst_done` one pulse; `burst_total=1`; no errors; `active=0` afterwards.
- Same burst, beat 5 data XOR 1 → `err_mismatch=1`, `err_total=1`, `first_err_addr=0x2400005`; burst still completes.
- Queue 4 bursts of cnt=2, then a fifth `req_valid` → `req_ready=0`, `err_proto=1`. 8 beats back-to-back → 4 `burst_done` pulses on consecutive odd beats.
- Push cnt=4, send 2 beats, then idle 1023 cycles → `err_timeout=1`, `active=0`, `burst_total=0`. A later `dout_ready` → `err_overrun=1`.
- `clear` on the same cycle as a mismatching beat → `err_total=1`, `err_mismatch=1`. Assert `reset_n=0` mid-burst → all outputs 0, `req_ready=1`.
